// File: rtl/eth_tx_pkg.sv
// Shared constants, state encoding and beat layout for the Ethernet TX frame arbiter.
package eth_tx_pkg;

    localparam logic [1:0] BE_ALL = 2'd0;
    localparam logic [1:0] BE_1   = 2'd1;
    localparam logic [1:0] BE_2   = 2'd2;
    localparam logic [1:0] BE_3   = 2'd3;

    localparam int IFG_CYCLES_DEF = 3;
    localparam int MAX_WORDS_DEF  = 380;

    // Beat layout through the skid stage: {dat[31:0], be[1:0], sop, eop, err}
    localparam int BEAT_W = 37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/eth_tx_skid_buf.sv
// Two-entry registered ready/valid buffer; in_rdy is a register so upstream
// sees back-pressure one cycle after out_rdy falls.
module eth_tx_skid_buf
    import eth_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [BEAT_W-1:0] in_beat,
    output logic              out_vld,
    output logic [BEAT_W-1:0] out_beat,
    input  logic              out_rdy
);

    logic [BEAT_W-1:0] skid_beat;
    logic              skid_vld;
    logic              in_fire;

    assign in_rdy  = !skid_vld;
    assign in_fire = in_vld && !skid_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_beat  <= '0;
            skid_vld  <= 1'b0;
            skid_beat <= '0;
        end else if (!out_vld || out_rdy) begin
            if (skid_vld) begin
                out_beat <= skid_beat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= in_fire;
                if (in_fire) begin
                    out_beat <= in_beat;
                end
            end
        end else if (in_fire) begin
            // output stalled: park the in-flight beat
            skid_vld  <= 1'b1;
            skid_beat <= in_beat;
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin whole-frame arbiter for the 32-bit Ethernet TX datapath with IFG insertion.
// Optional max-length truncation is enabled by defining TX_ARB_MAXLEN_EN.
//
// state | meaning
// IDLE  | pick the next requester round-robin (one decision cycle)
// XFER  | forward the granted source's frame; stray pre-sop beats are dropped
// GAP   | hold all sources off for IFG_CYCLES cycles
// FLUSH | discard the tail of a truncated frame up to its eop
module eth_tx_frame_arbiter
    import eth_tx_pkg::*;
#(
    parameter int SOURCE_NUMBER = 2,
    parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
    parameter int MAX_WORDS     = MAX_WORDS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SOURCE_NUMBER-1:0]   vld_in,
    input  logic [SOURCE_NUMBER*32-1:0] dat_in,
    input  logic [SOURCE_NUMBER*2-1:0] be_in,
    input  logic [SOURCE_NUMBER-1:0]   sop_in,
    input  logic [SOURCE_NUMBER-1:0]   eop_in,
    output logic [SOURCE_NUMBER-1:0]   rdy_out,
    output logic [SOURCE_NUMBER-1:0]   grant_out,
    output logic [31:0]                tx_dat,
    output logic [1:0]                 tx_be,
    output logic                       tx_sop,
    output logic                       tx_eop,
    output logic                       tx_err,
    output logic                       tx_vld,
    input  logic                       tx_rdy,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int GW  = clog2_min1(SOURCE_NUMBER);
    localparam int GCW = clog2_min1(IFG_CYCLES + 1);
    localparam logic [GCW-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GCW'(IFG_CYCLES - 1) : '0;
    localparam state_t AFTER_EOP = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t            state, state_nxt;
    logic [GW-1:0]     g_idx, ptr, win;
    logic [GCW-1:0]    gap_cnt;
    logic              in_frame;
    logic              any_req;
    int                idx;

    logic              cur_vld, cur_sop, cur_eop;
    logic [31:0]       cur_dat;
    logic [1:0]        cur_be;

    logic              skid_in_rdy;
    logic              push, drop, frame_inc, rel_grant, trunc, load_grant;
    logic [BEAT_W-1:0] push_beat, out_beat;

    assign cur_vld = vld_in[g_idx];
    assign cur_sop = sop_in[g_idx];
    assign cur_eop = eop_in[g_idx];
    assign cur_dat = dat_in[32*int'(g_idx) +: 32];
    assign cur_be  = be_in[2*int'(g_idx) +: 2];

    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < SOURCE_NUMBER; k++) begin
            idx = int'(ptr) + k;
            if (idx >= SOURCE_NUMBER) begin
                idx = idx - SOURCE_NUMBER;
            end
            if (!any_req && vld_in[GW'(idx)]) begin
                any_req = 1'b1;
                win     = GW'(idx);
            end
        end
    end

`ifdef TX_ARB_MAXLEN_EN
    localparam int BW = clog2_min1(MAX_WORDS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_WORDS - 1);
    logic [BW-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (rel_grant || trunc) begin
            beat_cnt <= '0;
        end else if (push) begin
            beat_cnt <= beat_cnt + BW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rdy_out    = '0;
        push       = 1'b0;
        drop       = 1'b0;
        frame_inc  = 1'b0;
        rel_grant  = 1'b0;
        trunc      = 1'b0;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load_grant = 1'b1;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                rdy_out[g_idx] = skid_in_rdy;
                if (cur_vld && skid_in_rdy) begin
                    if (!in_frame && !cur_sop) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (cur_eop) begin
                            frame_inc = 1'b1;
                            rel_grant = 1'b1;
                            state_nxt = AFTER_EOP;
                        end
`ifdef TX_ARB_MAXLEN_EN
                        else if (beat_cnt == LAST_BEAT) begin
                            trunc     = 1'b1;
                            frame_inc = 1'b1;
                            state_nxt = FLUSH;
                        end
`endif
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
`ifdef TX_ARB_MAXLEN_EN
            FLUSH: begin
                rdy_out[g_idx] = 1'b1;
                if (cur_vld) begin
                    drop = 1'b1;
                    if (cur_eop) begin
                        rel_grant = 1'b1;
                        state_nxt = AFTER_EOP;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_idx     <= '0;
            ptr       <= '0;
            grant_out <= '0;
            in_frame  <= 1'b0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load_grant) begin
                g_idx     <= win;
                grant_out <= SOURCE_NUMBER'(1) << win;
            end
            if (rel_grant) begin
                grant_out <= '0;
                ptr       <= (g_idx == GW'(SOURCE_NUMBER - 1)) ? '0 : g_idx + GW'(1);
            end
            if (rel_grant || trunc) begin
                in_frame <= 1'b0;
            end else if (push) begin
                in_frame <= 1'b1;
            end
            if (rel_grant) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GCW'(1);
            end
            frame_cnt <= frame_cnt + 16'(frame_inc);
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // a truncated beat always closes the frame as a full, errored word
    assign push_beat = {cur_dat, trunc ? BE_ALL : cur_be, cur_sop, cur_eop | trunc, trunc};

    eth_tx_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (push),
        .in_rdy   (skid_in_rdy),
        .in_beat  (push_beat),
        .out_vld  (tx_vld),
        .out_beat (out_beat),
        .out_rdy  (tx_rdy)
    );

    assign {tx_dat, tx_be, tx_sop, tx_eop, tx_err} = out_beat;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: two sources, IFG_CYCLES = 3.
module tb_eth_tx_frame_arbiter;

    localparam int NS  = 2;
    localparam int IFG = 3;
`ifdef TX_ARB_MAXLEN_EN
    localparam int MW = 4;
`else
    localparam int MW = 380;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NS-1:0]     vld_in, sop_in, eop_in;
    logic [NS*32-1:0]  dat_in;
    logic [NS*2-1:0]   be_in;
    logic [NS-1:0]     rdy_out, grant_out;
    logic [31:0]       tx_dat;
    logic [1:0]        tx_be;
    logic              tx_sop, tx_eop, tx_err, tx_vld, tx_rdy;
    logic [15:0]       frame_cnt, drop_cnt;

    eth_tx_frame_arbiter #(
        .SOURCE_NUMBER (NS),
        .IFG_CYCLES    (IFG),
        .MAX_WORDS     (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld_in    (vld_in),
        .dat_in    (dat_in),
        .be_in     (be_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .rdy_out   (rdy_out),
        .grant_out (grant_out),
        .tx_dat    (tx_dat),
        .tx_be     (tx_be),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_err    (tx_err),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  be;
        logic        sop;
        logic        eop;
    } sbeat_t;

    sbeat_t        q0[$], q1[$];
    logic [36:0]   rx_q[$], exp_q[$];
    int            rx_cyc[$], acc_cyc[$];
    logic [NS-1:0] ghist[$];
    logic [NS-1:0] rdy_log [0:1023];
    logic [NS-1:0] xfer, prev_grant, s_grant;
    logic          prev_stall, s_tx_vld;
    logic [35:0]   prev_out;
    int            cyc, viol, n_chk, n_fail, stall_s, zeros;
    int            acc_n [NS];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        sbeat_t b;
        for (int s = 0; s < NS; s++) begin
            b = '0;
            vld_in[s] = 1'b0;
            if (s == 0 && q0.size() > 0) begin b = q0[0]; vld_in[s] = 1'b1; end
            if (s == 1 && q1.size() > 0) begin b = q1[0]; vld_in[s] = 1'b1; end
            dat_in[s*32 +: 32] = b.dat;
            be_in[s*2 +: 2]    = b.be;
            sop_in[s]          = b.sop;
            eop_in[s]          = b.eop;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        cyc++;
        if (cyc < 1024) rdy_log[cyc] = rdy_out;
        xfer = vld_in & rdy_out;
        for (int s = 0; s < NS; s++) begin
            if (xfer[s]) begin
                acc_n[s]++;
                acc_cyc.push_back(cyc);
            end
        end
        if (tx_vld && tx_rdy) begin
            rx_q.push_back({tx_dat, tx_be, tx_sop, tx_eop, tx_err});
            rx_cyc.push_back(cyc);
        end
        if (prev_stall && ({tx_vld, tx_dat, tx_be, tx_sop, tx_eop} != {1'b1, prev_out})) viol++;
        prev_stall = tx_vld && !tx_rdy;
        prev_out   = {tx_dat, tx_be, tx_sop, tx_eop};
        if (grant_out != '0 && prev_grant == '0) ghist.push_back(grant_out);
        prev_grant = grant_out;
        s_grant    = grant_out;
        s_tx_vld   = tx_vld;
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
        if (xfer[0] && q0.size() > 0) void'(q0.pop_front());
        if (xfer[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        rx_q.delete(); exp_q.delete(); rx_cyc.delete(); acc_cyc.delete(); ghist.delete();
        cyc = 0; viol = 0; prev_stall = 1'b0; prev_grant = '0;
        for (int s = 0; s < NS; s++) acc_n[s] = 0;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        drive();
        tx_rdy = 1'b1;
        rst    = 1'b1;
        run(3);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic add_frame(input int src, input logic [31:0] base, input int n,
                             input logic [1:0] be, input bit want);
        sbeat_t b;
        for (int k = 0; k < n; k++) begin
            b.dat = base + 32'(k);
            b.sop = (k == 0);
            b.eop = (k == n - 1);
            b.be  = (k == n - 1) ? be : 2'd0;
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            if (want) exp_q.push_back({b, 1'b0});
        end
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_beats"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; tx_rdy = 1'b1;
        vld_in = '0; sop_in = '0; eop_in = '0; dat_in = '0; be_in = '0;

        // reset state
        do_reset();
        chk("rst_tx_vld", 64'(tx_vld), 0);
        chk("rst_grant", 64'(grant_out), 0);
        chk("rst_rdy", 64'(rdy_out), 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0);
        chk("rst_drop_cnt", 64'(drop_cnt), 0);
        chk("rst_tx_fields", 64'({tx_dat, tx_be, tx_sop, tx_eop, tx_err}), 0);

        // single 3-beat frame, be = 2 on eop
        add_frame(0, 32'hA000_0000, 3, 2'd2, 1'b1);
        drive();
        run(15);
        cmp_rx("t1");
        chk("t1_frame_cnt", 64'(frame_cnt), 1);
        if (acc_cyc.size() > 0 && rx_cyc.size() > 0)
            chk("t1_latency", 64'(rx_cyc[0] - acc_cyc[0]), 1);
        if (acc_cyc.size() >= 3) begin
            zeros = 0;
            for (int c = acc_cyc[2] + 1; c <= acc_cyc[2] + 3; c++) if (rdy_log[c] == '0) zeros++;
            chk("t1_rdy_gap", 64'(zeros), 3);
        end

        // two sources with back-to-back 2-beat frames
        do_reset();
        add_frame(0, 32'h0A00_0000, 2, 2'd1, 1'b1);
        add_frame(1, 32'h0B00_0000, 2, 2'd2, 1'b1);
        add_frame(0, 32'h0C00_0000, 2, 2'd3, 1'b1);
        add_frame(1, 32'h0D00_0000, 2, 2'd0, 1'b1);
        drive();
        run(40);
        cmp_rx("t2");
        chk("t2_grants", 64'(ghist.size()), 4);
        for (int i = 0; i < ghist.size() && i < 4; i++)
            chk($sformatf("t2_grant%0d", i), 64'(ghist[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        // IFG cycles in GAP plus the one IDLE decision cycle
        if (rx_cyc.size() >= 3)
            chk("t2_tx_gap", 64'(rx_cyc[2] - rx_cyc[1] - 1), 64'(IFG + 1));
        chk("t2_frame_cnt", 64'(frame_cnt), 4);

        // downstream stall for 4 cycles mid-frame
        do_reset();
        add_frame(0, 32'h3000_0000, 6, 2'd1, 1'b1);
        drive();
        for (int t = 0; t < 50 && rx_q.size() < 2; t++) step();
        chk("t3_reach", 64'(rx_q.size() >= 2), 1);
        stall_s = cyc + 1;
        tx_rdy  = 1'b0;
        run(4);
        tx_rdy = 1'b1;
        run(20);
        cmp_rx("t3");
        chk("t3_stable", 64'(viol), 0);
        chk("t3_rdy_absorb", 64'(rdy_log[stall_s][0]), 1);
        chk("t3_rdy_drop", 64'(rdy_log[stall_s + 1][0]), 0);

        // stray beat without sop ahead of a valid frame
        do_reset();
        q0.push_back('{dat: 32'hDEAD_BEEF, be: 2'd0, sop: 1'b0, eop: 1'b0});
        add_frame(0, 32'h4000_0000, 3, 2'd3, 1'b1);
        drive();
        run(20);
        cmp_rx("t4");
        chk("t4_drop_cnt", 64'(drop_cnt), 1);
        chk("t4_frame_cnt", 64'(frame_cnt), 1);

        // reset on beat 2 of a 5-beat frame, then a frame from source 1
        do_reset();
        add_frame(0, 32'h5000_0000, 5, 2'd0, 1'b0);
        drive();
        for (int t = 0; t < 50 && acc_n[0] < 2; t++) step();
        chk("t5_reach", 64'(acc_n[0]), 2);
        rst = 1'b1;
        step();
        q0.delete();
        drive();
        rst = 1'b0;
        step();
        chk("t5_tx_vld", 64'(s_tx_vld), 0);
        chk("t5_grant", 64'(s_grant), 0);
        clear_logs();
        add_frame(1, 32'h5100_0000, 3, 2'd2, 1'b1);
        drive();
        run(20);
        chk("t5_grants", 64'(ghist.size()), 1);
        if (ghist.size() > 0) chk("t5_first_grant", 64'(ghist[0]), 64'h2);
        cmp_rx("t5");

`ifdef TX_ARB_MAXLEN_EN
        // 6-beat frame against MAX_WORDS = 4
        do_reset();
        add_frame(0, 32'h6000_0000, 6, 2'd1, 1'b0);
        exp_q.push_back({32'h6000_0000, 2'd0, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({32'h6000_0001, 2'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({32'h6000_0002, 2'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({32'h6000_0003, 2'd0, 1'b0, 1'b1, 1'b1});
        drive();
        run(30);
        cmp_rx("t6");
        chk("t6_drop_cnt", 64'(drop_cnt), 2);
        chk("t6_frame_cnt", 64'(frame_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
